// File: rtl/alu_rs_if.sv
// Issue, result-broadcast and ALU-dispatch bundle shared by the
// reservation station and its neighbours.
interface alu_rs_if #(
    parameter int ROB_INDEX_BIT = 4,
    parameter int TYPE_BIT      = 5
);
    // issue port
    logic                     issue_valid;
    logic [TYPE_BIT-1:0]      issue_type;
    logic [ROB_INDEX_BIT-1:0] issue_dest;
    logic [31:0]              issue_vj;
    logic [31:0]              issue_vk;
    logic                     issue_qj_pend;
    logic                     issue_qk_pend;
    logic [ROB_INDEX_BIT-1:0] issue_qj;
    logic [ROB_INDEX_BIT-1:0] issue_qk;
    // result broadcast buses (0: ALU, 1: load-store)
    logic                     cdb0_valid;
    logic [ROB_INDEX_BIT-1:0] cdb0_rob_id;
    logic [31:0]              cdb0_value;
    logic                     cdb1_valid;
    logic [ROB_INDEX_BIT-1:0] cdb1_rob_id;
    logic [31:0]              cdb1_value;
    // station status and dispatch
    logic                     full;
    logic                     alu_req;
    logic [TYPE_BIT-1:0]      alu_type;
    logic [31:0]              alu_r1;
    logic [31:0]              alu_r2;
    logic [ROB_INDEX_BIT-1:0] alu_rob_id;

    modport master (
        output issue_valid, issue_type, issue_dest, issue_vj, issue_vk,
               issue_qj_pend, issue_qk_pend, issue_qj, issue_qk,
               cdb0_valid, cdb0_rob_id, cdb0_value,
               cdb1_valid, cdb1_rob_id, cdb1_value,
        input  full, alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
    );

    modport slave (
        input  issue_valid, issue_type, issue_dest, issue_vj, issue_vk,
               issue_qj_pend, issue_qk_pend, issue_qj, issue_qk,
               cdb0_valid, cdb0_rob_id, cdb0_value,
               cdb1_valid, cdb1_rob_id, cdb1_value,
        output full, alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued instructions until both operands
// are known, snoops two result buses, and dispatches the lowest-index
// ready entry to the ALU through registered outputs.
module alu_rs #(
    parameter int RS_SIZE       = 8,
    parameter int ROB_INDEX_BIT = 4,
    parameter int TYPE_BIT      = 5
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    input  logic    flush_in,
    alu_rs_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Resolve one operand against both buses; cdb0 wins if both carry the tag.
    function automatic logic [32:0] snoop_operand(
        input logic                     pend,
        input logic [ROB_INDEX_BIT-1:0] tag,
        input logic [31:0]              value,
        input logic                     c0_v,
        input logic [ROB_INDEX_BIT-1:0] c0_id,
        input logic [31:0]              c0_val,
        input logic                     c1_v,
        input logic [ROB_INDEX_BIT-1:0] c1_id,
        input logic [31:0]              c1_val
    );
        logic [32:0] res;
        if (pend && c0_v && (c0_id == tag)) begin
            res = {1'b0, c0_val};
        end else if (pend && c1_v && (c1_id == tag)) begin
            res = {1'b0, c1_val};
        end else begin
            res = {pend, value};
        end
        return res;
    endfunction

    // Index of the lowest set bit (0 when none is set; callers gate on |vec).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [RS_SIZE-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // entry storage
    logic [RS_SIZE-1:0]       busy_r;
    logic [RS_SIZE-1:0]       qj_pend_r;
    logic [RS_SIZE-1:0]       qk_pend_r;
    logic [TYPE_BIT-1:0]      op_r   [RS_SIZE];
    logic [31:0]              vj_r   [RS_SIZE];
    logic [31:0]              vk_r   [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] qj_r   [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] qk_r   [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] dest_r [RS_SIZE];

    // next-state values
    logic [RS_SIZE-1:0]       busy_n_s;
    logic [RS_SIZE-1:0]       qj_pend_n_s;
    logic [RS_SIZE-1:0]       qk_pend_n_s;
    logic [TYPE_BIT-1:0]      op_n_s   [RS_SIZE];
    logic [31:0]              vj_n_s   [RS_SIZE];
    logic [31:0]              vk_n_s   [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] qj_n_s   [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] qk_n_s   [RS_SIZE];
    logic [ROB_INDEX_BIT-1:0] dest_n_s [RS_SIZE];

    // dispatch registers
    logic                     alu_req_r;
    logic [TYPE_BIT-1:0]      alu_type_r;
    logic [31:0]              alu_r1_r;
    logic [31:0]              alu_r2_r;
    logic [ROB_INDEX_BIT-1:0] alu_rob_id_r;
    logic                     alu_req_n_s;
    logic [TYPE_BIT-1:0]      alu_type_n_s;
    logic [31:0]              alu_r1_n_s;
    logic [31:0]              alu_r2_n_s;
    logic [ROB_INDEX_BIT-1:0] alu_rob_id_n_s;

    // selection
    logic [RS_SIZE-1:0] ready_s;
    logic               sel_valid_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               full_s;
    logic               issue_go_s;
    logic [32:0]        issue_j_s;
    logic [32:0]        issue_k_s;

    // Readiness, free slot and issue-time operand bypass, all from registered state.
    always_comb begin
        ready_s     = busy_r & ~qj_pend_r & ~qk_pend_r;
        sel_valid_s = |ready_s;
        sel_idx_s   = lowest_set(ready_s);
        full_s      = &busy_r;
        free_idx_s  = lowest_set(~busy_r);
        issue_go_s  = bus.issue_valid & ~full_s;
        issue_j_s   = snoop_operand(bus.issue_qj_pend, bus.issue_qj, bus.issue_vj,
                                    bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                                    bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
        issue_k_s   = snoop_operand(bus.issue_qk_pend, bus.issue_qk, bus.issue_vk,
                                    bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                                    bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
    end

    // Entry next state: wakeup, release of the dispatched entry, issue write, flush.
    always_comb begin
        busy_n_s    = busy_r;
        qj_pend_n_s = qj_pend_r;
        qk_pend_n_s = qk_pend_r;
        for (int i = 0; i < RS_SIZE; i++) begin
            op_n_s[i]   = op_r[i];
            vj_n_s[i]   = vj_r[i];
            vk_n_s[i]   = vk_r[i];
            qj_n_s[i]   = qj_r[i];
            qk_n_s[i]   = qk_r[i];
            dest_n_s[i] = dest_r[i];
            if (busy_r[i]) begin
                {qj_pend_n_s[i], vj_n_s[i]} = snoop_operand(qj_pend_r[i], qj_r[i], vj_r[i],
                    bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                    bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
                {qk_pend_n_s[i], vk_n_s[i]} = snoop_operand(qk_pend_r[i], qk_r[i], vk_r[i],
                    bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                    bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
            end else begin
                qj_pend_n_s[i] = qj_pend_r[i];
                qk_pend_n_s[i] = qk_pend_r[i];
            end
        end
        if (sel_valid_s) begin
            busy_n_s[sel_idx_s] = 1'b0;
        end else begin
            busy_n_s = busy_n_s;
        end
        // the free slot is never the dispatched one, so these writes cannot collide
        if (issue_go_s) begin
            busy_n_s[free_idx_s]    = 1'b1;
            op_n_s[free_idx_s]      = bus.issue_type;
            dest_n_s[free_idx_s]    = bus.issue_dest;
            qj_n_s[free_idx_s]      = bus.issue_qj;
            qk_n_s[free_idx_s]      = bus.issue_qk;
            qj_pend_n_s[free_idx_s] = issue_j_s[32];
            vj_n_s[free_idx_s]      = issue_j_s[31:0];
            qk_pend_n_s[free_idx_s] = issue_k_s[32];
            vk_n_s[free_idx_s]      = issue_k_s[31:0];
        end else begin
            busy_n_s = busy_n_s;
        end
        if (flush_in) begin
            busy_n_s = {RS_SIZE{1'b0}};
        end else begin
            busy_n_s = busy_n_s;
        end
    end

    // Dispatch payload for the coming edge; payload holds when nothing is sent.
    always_comb begin
        alu_req_n_s    = 1'b0;
        alu_type_n_s   = alu_type_r;
        alu_r1_n_s     = alu_r1_r;
        alu_r2_n_s     = alu_r2_r;
        alu_rob_id_n_s = alu_rob_id_r;
        if (flush_in) begin
            alu_req_n_s = 1'b0;
        end else if (sel_valid_s) begin
            alu_req_n_s    = 1'b1;
            alu_type_n_s   = op_r[sel_idx_s];
            alu_r1_n_s     = vj_r[sel_idx_s];
            alu_r2_n_s     = vk_r[sel_idx_s];
            alu_rob_id_n_s = dest_r[sel_idx_s];
        end else begin
            alu_req_n_s = 1'b0;
        end
    end

    // State update: reset dominates, then a low global ready freezes everything.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_r       <= {RS_SIZE{1'b0}};
            qj_pend_r    <= {RS_SIZE{1'b0}};
            qk_pend_r    <= {RS_SIZE{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]   <= {TYPE_BIT{1'b0}};
                vj_r[i]   <= 32'd0;
                vk_r[i]   <= 32'd0;
                qj_r[i]   <= {ROB_INDEX_BIT{1'b0}};
                qk_r[i]   <= {ROB_INDEX_BIT{1'b0}};
                dest_r[i] <= {ROB_INDEX_BIT{1'b0}};
            end
            alu_req_r    <= 1'b0;
            alu_type_r   <= {TYPE_BIT{1'b0}};
            alu_r1_r     <= 32'd0;
            alu_r2_r     <= 32'd0;
            alu_rob_id_r <= {ROB_INDEX_BIT{1'b0}};
        end else if (rdy_in) begin
            busy_r       <= busy_n_s;
            qj_pend_r    <= qj_pend_n_s;
            qk_pend_r    <= qk_pend_n_s;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]   <= op_n_s[i];
                vj_r[i]   <= vj_n_s[i];
                vk_r[i]   <= vk_n_s[i];
                qj_r[i]   <= qj_n_s[i];
                qk_r[i]   <= qk_n_s[i];
                dest_r[i] <= dest_n_s[i];
            end
            alu_req_r    <= alu_req_n_s;
            alu_type_r   <= alu_type_n_s;
            alu_r1_r     <= alu_r1_n_s;
            alu_r2_r     <= alu_r2_n_s;
            alu_rob_id_r <= alu_rob_id_n_s;
        end
    end

    assign bus.full       = full_s;
    assign bus.alu_req    = alu_req_r;
    assign bus.alu_type   = alu_type_r;
    assign bus.alu_r1     = alu_r1_r;
    assign bus.alu_r2     = alu_r2_r;
    assign bus.alu_rob_id = alu_rob_id_r;
endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a per-cycle entry-table model predicts the
// dispatch outputs after every edge and the full flag; a monitor compares.
module tb_alu_rs;
    localparam int RS = 8;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_in;

    always #5 clk_in = ~clk_in;

    alu_rs_if #(.ROB_INDEX_BIT(4), .TYPE_BIT(5)) bus ();

    alu_rs #(.RS_SIZE(RS), .ROB_INDEX_BIT(4), .TYPE_BIT(5)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    typedef struct {
        logic        rst, rdy, flush, iv;
        logic [4:0]  typ;
        logic [3:0]  dest;
        logic [31:0] vj, vk;
        logic        jp, kp;
        logic [3:0]  qj, qk;
        logic        c0v;
        logic [3:0]  c0id;
        logic [31:0] c0val;
        logic        c1v;
        logic [3:0]  c1id;
        logic [31:0] c1val;
    } stim_t;

    typedef struct packed {
        logic        req;
        logic [4:0]  typ;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  id;
    } out_t;

    typedef struct {
        logic        busy;
        logic [4:0]  typ;
        logic [31:0] vj, vk;
        logic        jp, kp;
        logic [3:0]  qj, qk, dest;
    } ent_t;

    ent_t  m [RS];
    out_t  m_out;
    out_t  exp_q [$];
    int    tests = 0;
    int    fails = 0;
    bit    running = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.rdy = 1'b1; s.flush = 1'b0; s.iv = 1'b0;
        s.typ = 5'd0; s.dest = 4'd0; s.vj = 32'd0; s.vk = 32'd0;
        s.jp = 1'b0; s.kp = 1'b0; s.qj = 4'd0; s.qk = 4'd0;
        s.c0v = 1'b0; s.c0id = 4'd0; s.c0val = 32'd0;
        s.c1v = 1'b0; s.c1id = 4'd0; s.c1val = 32'd0;
        return s;
    endfunction

    // A pending operand becomes known if any valid bus carries its tag (cdb0 first).
    function automatic logic [32:0] resolve(input logic pend, input logic [31:0] v,
                                            input logic [3:0] tag, input stim_t s);
        if (!pend) return {1'b0, v};
        if (s.c0v && s.c0id == tag) return {1'b0, s.c0val};
        if (s.c1v && s.c1id == tag) return {1'b0, s.c1val};
        return {1'b1, v};
    endfunction

    function automatic logic model_full();
        logic f;
        f = 1'b1;
        for (int i = 0; i < RS; i++) f = f & m[i].busy;
        return f;
    endfunction

    // Drive one cycle of inputs, advance the model over the coming edge, check full afterwards.
    task automatic step(input stim_t s);
        ent_t        old [RS];
        int          sel;
        int          free;
        logic [32:0] r;
        rst_in            = s.rst;
        rdy_in            = s.rdy;
        flush_in          = s.flush;
        bus.issue_valid   = s.iv;
        bus.issue_type    = s.typ;
        bus.issue_dest    = s.dest;
        bus.issue_vj      = s.vj;
        bus.issue_vk      = s.vk;
        bus.issue_qj_pend = s.jp;
        bus.issue_qk_pend = s.kp;
        bus.issue_qj      = s.qj;
        bus.issue_qk      = s.qk;
        bus.cdb0_valid    = s.c0v;
        bus.cdb0_rob_id   = s.c0id;
        bus.cdb0_value    = s.c0val;
        bus.cdb1_valid    = s.c1v;
        bus.cdb1_rob_id   = s.c1id;
        bus.cdb1_value    = s.c1val;
        old = m;
        if (!s.rst) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            m_out = '0;
        end else if (!s.rdy) begin
            m_out = m_out;
        end else if (s.flush) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            m_out.req = 1'b0;
        end else begin
            sel  = -1;
            free = -1;
            for (int i = 0; i < RS; i++) begin
                if (sel < 0 && old[i].busy && !old[i].jp && !old[i].kp) sel = i;
                if (free < 0 && !old[i].busy) free = i;
                if (old[i].busy) begin
                    r = resolve(old[i].jp, old[i].vj, old[i].qj, s);
                    m[i].jp = r[32]; m[i].vj = r[31:0];
                    r = resolve(old[i].kp, old[i].vk, old[i].qk, s);
                    m[i].kp = r[32]; m[i].vk = r[31:0];
                end
            end
            if (sel >= 0) begin
                m_out.req = 1'b1;
                m_out.typ = old[sel].typ;
                m_out.r1  = old[sel].vj;
                m_out.r2  = old[sel].vk;
                m_out.id  = old[sel].dest;
                m[sel].busy = 1'b0;
            end else begin
                m_out.req = 1'b0;
            end
            if (s.iv && free >= 0) begin
                m[free].busy = 1'b1;
                m[free].typ  = s.typ;
                m[free].dest = s.dest;
                m[free].qj   = s.qj;
                m[free].qk   = s.qk;
                r = resolve(s.jp, s.vj, s.qj, s);
                m[free].jp = r[32]; m[free].vj = r[31:0];
                r = resolve(s.kp, s.vk, s.qk, s);
                m[free].kp = r[32]; m[free].vk = r[31:0];
            end
        end
        exp_q.push_back(m_out);
        @(negedge clk_in);
        tests++;
        if (bus.full !== model_full()) begin
            fails++;
            $display("FAIL full @%0t got=%b exp=%b", $time, bus.full, model_full());
        end
    endtask

    // Monitor: after every edge compare the dispatch outputs with the oldest prediction.
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clk_in);
            #1;
            if (running) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty @%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = {bus.alu_req, bus.alu_type, bus.alu_r1, bus.alu_r2, bus.alu_rob_id};
                    if (a !== e) begin
                        fails++;
                        $display("FAIL dispatch @%0t got req=%b type=%h r1=%h r2=%h id=%h exp req=%b type=%h r1=%h r2=%h id=%h",
                                 $time, a.req, a.typ, a.r1, a.r2, a.id, e.req, e.typ, e.r1, e.r2, e.id);
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < RS; i++) begin
            m[i].busy = 1'b0; m[i].typ = 5'd0; m[i].vj = 32'd0; m[i].vk = 32'd0;
            m[i].jp = 1'b0; m[i].kp = 1'b0; m[i].qj = 4'd0; m[i].qk = 4'd0; m[i].dest = 4'd0;
        end
        m_out = '0;
        s = idle();
        s.rst = 1'b0;
        rst_in = 1'b0; rdy_in = 1'b0; flush_in = 1'b1;
        @(negedge clk_in);
        running = 1'b1;
        // reset with rdy low and flush high still clears everything
        s.rdy = 1'b0; s.flush = 1'b1; step(s);
        s = idle(); s.rst = 1'b0; step(s);

        // plain issue right after reset, then dispatch one cycle later
        s = idle(); s.iv = 1'b1; s.typ = 5'd0; s.vj = 32'd3; s.vk = 32'd4; s.dest = 4'd2; step(s);
        s = idle(); step(s); step(s); step(s);

        // wake from cdb1, then issue-time bypass from cdb0
        s = idle(); s.iv = 1'b1; s.typ = 5'd1; s.jp = 1'b1; s.qj = 4'd5; s.vk = 32'd7; s.dest = 4'd1; step(s);
        s = idle(); step(s); step(s);
        s = idle(); s.c1v = 1'b1; s.c1id = 4'd5; s.c1val = 32'h10; step(s);
        s = idle(); step(s); step(s);
        s = idle(); s.iv = 1'b1; s.typ = 5'd2; s.jp = 1'b1; s.qj = 4'd6; s.vk = 32'd9; s.dest = 4'd3;
        s.c0v = 1'b1; s.c0id = 4'd6; s.c0val = 32'h55; step(s);
        s = idle(); step(s); step(s);

        // fill all entries pending, ignore the extra issue, wake entry 6, refill it
        for (int i = 0; i < RS; i++) begin
            s = idle(); s.iv = 1'b1; s.typ = 5'(i); s.jp = 1'b1; s.qj = 4'(8 + i);
            s.vk = 32'(100 + i); s.dest = 4'(i); step(s);
        end
        s = idle(); s.iv = 1'b1; s.typ = 5'd9; s.vj = 32'd1; s.vk = 32'd2; s.dest = 4'd9; step(s);
        s = idle(); s.c0v = 1'b1; s.c0id = 4'd14; s.c0val = 32'habc; step(s);
        s = idle(); step(s);
        s = idle(); step(s);
        s = idle(); s.iv = 1'b1; s.typ = 5'd12; s.vj = 32'h66; s.vk = 32'h77; s.dest = 4'd12; step(s);
        s = idle(); step(s); step(s);
        s = idle(); s.flush = 1'b1; step(s);

        // entries 1 and 3 become ready together: lower index goes first
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.iv = 1'b1; s.typ = 5'(20 + i); s.jp = 1'b1; s.qj = 4'(1 + i);
            s.vk = 32'(200 + i); s.dest = 4'(4 + i); step(s);
        end
        s = idle(); s.c0v = 1'b1; s.c0id = 4'd2; s.c0val = 32'h111;
        s.c1v = 1'b1; s.c1id = 4'd4; s.c1val = 32'h333; step(s);
        s = idle(); step(s); step(s); step(s);
        s = idle(); s.flush = 1'b1; step(s);

        // flush with five busy entries drops the issue offered alongside it
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.iv = 1'b1; s.jp = 1'b1; s.qj = 4'd9; s.dest = 4'(i); step(s);
        end
        s = idle(); s.flush = 1'b1; s.iv = 1'b1; s.vj = 32'd5; s.vk = 32'd6; s.dest = 4'd7; step(s);
        s = idle(); step(s); step(s); step(s);

        // stall with ready entries and bus traffic, then reset mid-dispatch
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iv = 1'b1; s.typ = 5'(3 + i); s.vj = 32'(30 + i); s.vk = 32'(40 + i);
            s.dest = 4'(4 + i); step(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rdy = 1'b0; s.iv = 1'b1; s.dest = 4'd15; s.vj = 32'hdead;
            s.c0v = 1'b1; s.c0id = 4'd9; s.c0val = 32'hbeef; step(s);
        end
        s = idle(); step(s);
        s = idle(); s.rst = 1'b0; step(s);
        s = idle(); step(s); step(s);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 199) != 0);
            s.rdy   = ($urandom_range(0, 99) < 85);
            s.flush = ($urandom_range(0, 99) < 3);
            s.iv    = ($urandom_range(0, 99) < 60);
            s.typ   = 5'($urandom_range(0, 31));
            s.dest  = 4'($urandom_range(0, 15));
            s.vj    = $urandom;
            s.vk    = $urandom;
            s.jp    = ($urandom_range(0, 99) < 40);
            s.kp    = ($urandom_range(0, 99) < 40);
            s.qj    = 4'($urandom_range(0, 3));
            s.qk    = 4'($urandom_range(0, 3));
            s.c0v   = ($urandom_range(0, 99) < 40);
            s.c0id  = 4'($urandom_range(0, 3));
            s.c0val = $urandom;
            s.c1v   = ($urandom_range(0, 99) < 40);
            s.c1id  = 4'($urandom_range(0, 3));
            s.c1val = $urandom;
            step(s);
        end

        running = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_predictions got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
